// File: rtl/tsb_pkg.sv
// tsb_pkg: state encoding and counter sizing shared by the tristate bus arbiter files.
package tsb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_e;

   // Floor width of the shared TURN/hold counter: TURN spans 0..7.
   localparam int CNT_W_MIN = 3;

   function automatic int cnt_width(input int max_hold);
      int w;
      w = (max_hold > 0) ? $clog2(max_hold + 1) : 1;
      return (w > CNT_W_MIN) ? w : CNT_W_MIN;
   endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first set req bit
// strictly after ptr (wrapping), as one-hot and as an index.
module rr_picker #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [PW-1:0] pick_idx,
   output logic          valid
);

   always_comb begin
      logic found;
      int   idx;
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found          = 1'b1;
            pick[idx]      = 1'b1;
            pick_idx       = PW'(idx);
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin ownership of a shared tristate bus with a Hi-Z
// turnaround gap between owners. Define TRISTATE_TIMEOUT_EN for forced release.
module tristate_bus_arbiter
   import tsb_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int TURN     = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] din,
   output logic [N-1:0]   gnt,
   inout  wire  [W-1:0]   bus,
   output logic           bus_busy,
   output logic           timeout
);

   localparam int PW = $clog2(N);
   localparam int CW = cnt_width(MAX_HOLD);
   localparam logic [CW-1:0] TURN_LAST = (TURN > 0) ? CW'(TURN - 1) : '0;

   state_e        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] turn_q, turn_d;
   logic          timeout_q, timeout_d;

   logic [N-1:0]  pick;
   logic [PW-1:0] pick_idx;
   logic          pick_valid;
   logic          owner_req;
   logic          force_rel;

   rr_picker #(
      .N  (N),
      .PW (PW)
   ) u_picker (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx),
      .valid    (pick_valid)
   );

   // ptr always names the current (or most recent) owner.
   assign owner_req = req[ptr_q];

`ifdef TRISTATE_TIMEOUT_EN
   localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
   logic [CW-1:0] hold_q, hold_d;

   // hold_q equals the number of cycles the current owner has had gnt.
   always_comb begin
      hold_d = hold_q;
      if (state_q == ST_IDLE) begin
         hold_d = CW'(1);
      end else if (state_q == ST_OWN && hold_q != HOLD_LIM) begin
         hold_d = hold_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign force_rel = (hold_q >= HOLD_LIM);
`else
   assign force_rel = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      turn_d    = turn_q;
      timeout_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick;
               ptr_d   = pick_idx;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            if (!owner_req || force_rel) begin
               gnt_d     = '0;
               timeout_d = owner_req;
               turn_d    = TURN_LAST;
               state_d   = (TURN > 0) ? ST_TURN : ST_IDLE;
            end
         end
         ST_TURN: begin
            if (turn_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               turn_d = turn_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         ptr_q     <= PW'(N - 1);
         turn_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         turn_q    <= turn_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt      = gnt_q;
   assign bus_busy = (state_q != ST_IDLE);
   assign timeout  = timeout_q;

   // One tristate driver per requester; gnt_q is one-hot0 so at most one is enabled.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_drv
         assign bus = gnt_q[gi] ? din[gi*W +: W] : {W{1'bz}};
      end
   endgenerate

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed and random request patterns checked
// through a scoreboard fed by an integer-level model of the arbitration rules.
module tb_tristate_bus_arbiter;

   localparam int N        = 4;
   localparam int W        = 8;
   localparam int TURN     = 1;
   localparam int MAX_HOLD = 16;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N*W-1:0] din   = '0;
   logic [N-1:0]   gnt;
   wire  [W-1:0]   bus;
   logic           bus_busy;
   logic           timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [N-1:0] gnt;
      logic         busy;
      logic         tmo;
   } exp_t;

   exp_t exp_q[$];

   // Model: owner (-1 = none), Hi-Z cycles left before arbitration, last winner, held cycles.
   int m_owner = -1;
   int m_wait  = 0;
   int m_last  = N - 1;
   int m_hold  = 0;

   tristate_bus_arbiter #(
      .N        (N),
      .W        (W),
      .TURN     (TURN),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .din      (din),
      .gnt      (gnt),
      .bus      (bus),
      .bus_busy (bus_busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] need);
      checks++;
      if (act !== need) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, need, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_wait  = 0;
      m_last  = N - 1;
      m_hold  = 0;
      exp_q.delete();
   endtask

   // Predict the outputs after the next rising edge given the req sampled there.
   task automatic model_step(input logic [N-1:0] r);
      exp_t e;
      e.tmo = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1;
            m_wait  = TURN;
         end
`ifdef TRISTATE_TIMEOUT_EN
         else if (m_hold >= MAX_HOLD) begin
            m_owner = -1;
            m_wait  = TURN;
            e.tmo   = 1'b1;
         end
`endif
         else begin
            m_hold++;
         end
      end else if (m_wait > 0) begin
         m_wait--;
      end else if (r != '0) begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (r[i]) begin
               m_owner = i;
               m_last  = i;
               m_hold  = 1;
               break;
            end
         end
      end
      e.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e.busy = (m_owner >= 0) || (m_wait > 0);
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [N-1:0] r);
      @(negedge clk);
      req = r;
      for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
      model_step(r);
   endtask

   // Monitor: one expected entry per clock edge while the scoreboard is fed.
   always @(posedge clk) begin : monitor
      exp_t e;
      int   oi;
      #1;
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt", 32'(gnt), 32'(e.gnt));
         check("bus_busy", 32'(bus_busy), 32'(e.busy));
         check("timeout", 32'(timeout), 32'(e.tmo));
         if (e.gnt != '0) begin
            oi = 0;
            for (int i = 0; i < N; i++) if (e.gnt[i]) oi = i;
            check("bus_data", 32'(bus), 32'(din[oi*W +: W]));
         end
      end
   end

   logic [N-1:0] dir_vec [11] = '{4'b1111, 4'b1111, 4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                  4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0100};

   initial begin
      // Reset with every requester asking.
      rst_n = 1'b0;
      req   = 4'b1111;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(bus_busy), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      model_reset();
      rst_n = 1'b1;
      model_step(4'b1111);

      // Handover with turnaround: owner 0 -> 1 -> 2.
      foreach (dir_vec[i]) drive(dir_vec[i]);

      // Two requesters sharing: hold 3 cycles, drop for one.
      for (int c = 0; c < 40; c++) begin
         logic [N-1:0] r;
         r = 4'b1001;
         if (m_owner >= 0 && m_hold >= 3) r[m_owner] = 1'b0;
         drive(r);
      end

      // Asynchronous reset while requester 2 owns the bus.
      for (int c = 0; c < 8 && m_owner != 2; c++) drive(4'b0100);
      drive(4'b0100);
      @(posedge clk);
      #3;
      check("pre_rst_gnt", 32'(gnt), 32'(4'b0100));
      rst_n = 1'b0;
      #1;
      check("async_rst_gnt", 32'(gnt), 32'd0);
      check("async_rst_busy", 32'(bus_busy), 32'd0);
      model_reset();

      // Long ownership: requester 1 keeps the bus while requester 2 waits.
      repeat (2) @(negedge clk);
      req   = 4'b0110;
      rst_n = 1'b1;
      model_step(4'b0110);
      repeat (120) drive(4'b0110);
      @(posedge clk);
      #2;
      check("long_hold_gnt", 32'(gnt), 32'(4'b0010));

      // Random traffic; the owner drops its request about one cycle in four.
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] r;
         r = N'($urandom);
         if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 3) != 0);
         drive(r);
      end
      repeat (4) drive('0);

      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
